// File: rtl/bcd_entry_to_bin.sv
// Keypad decimal entry: accumulates BCD digits (mag*10 + digit), applies sign and range check on commit.
// Optional macro SATURATE_EN: out-of-range entries clamp to the signed limit instead of reading 0.
module bcd_entry_to_bin #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               digit_valid,
    input  logic [3:0]                         digit,
    input  logic                               sign_toggle,
    input  logic                               clear,
    input  logic                               commit,
    output logic                               busy,
    output logic [WIDTH-1:0]                   value,
    output logic                               value_valid,
    output logic                               overflow,
    output logic                               negative,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count
);

    localparam int MAG_W = 4 * MAX_DIGITS;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int CMP_W = ((MAG_W > WIDTH) ? MAG_W : WIDTH) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CMP_W-1:0] LIM_NEG = CMP_W'(1) << (WIDTH - 1);
    localparam logic [CMP_W-1:0] LIM_POS = LIM_NEG - CMP_W'(1);
`ifdef SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        ADD   = 3'd2,
        CONV  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_r, state_next;
    logic [MAG_W-1:0]   mag_r, mag_next;
    logic [MAG_W-1:0]   mul_r, mul_next;
    logic [3:0]         dig_r, dig_next;
    logic [CNT_W-1:0]   count_r, count_next;
    logic               neg_r, neg_next;
    logic [WIDTH-1:0]   res_r, res_next;
    logic               res_ovf_r, res_ovf_next;
    logic [WIDTH-1:0]   value_r, value_next;
    logic               overflow_r, overflow_next;
    logic               value_valid_r, value_valid_next;
    logic               busy_r, busy_next;

    logic [CMP_W-1:0]   mag_wide_s;
    logic [WIDTH-1:0]   mag_low_s;
    logic [WIDTH-1:0]   mag_neg_s;
    logic               conv_ovf_s;
    logic [WIDTH-1:0]   conv_value_s;
    logic               digit_ok_s;

    // Signed conversion of the accumulated magnitude; negation in WIDTH bits equals the truncated wider negation.
    always_comb begin
        mag_wide_s   = CMP_W'(mag_r);
        mag_low_s    = mag_wide_s[WIDTH-1:0];
        mag_neg_s    = -mag_low_s;
        conv_ovf_s   = mag_wide_s > (neg_r ? LIM_NEG : LIM_POS);
        conv_value_s = '0;
        if (conv_ovf_s) begin
`ifdef SATURATE_EN
            conv_value_s = neg_r ? SAT_NEG : SAT_POS;
`else
            conv_value_s = '0;
`endif
        end else begin
            conv_value_s = neg_r ? mag_neg_s : mag_low_s;
        end
    end

    assign digit_ok_s = (digit <= 4'd9) && (count_r < CNT_MAX);

    // Next-state and datapath updates; clear overrides every state.
    always_comb begin
        state_next       = state_r;
        mag_next         = mag_r;
        mul_next         = mul_r;
        dig_next         = dig_r;
        count_next       = count_r;
        neg_next         = neg_r;
        res_next         = res_r;
        res_ovf_next     = res_ovf_r;
        value_next       = value_r;
        overflow_next    = overflow_r;
        value_valid_next = 1'b0;
        if (clear) begin
            state_next    = IDLE;
            mag_next      = '0;
            count_next    = '0;
            neg_next      = 1'b0;
            overflow_next = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (commit) begin
                        state_next = CONV;
                    end else if (digit_valid) begin
                        if (digit_ok_s) begin
                            dig_next   = digit;
                            state_next = SHIFT;
                        end else begin
                            state_next = IDLE;
                        end
                    end else if (sign_toggle) begin
                        neg_next = ~neg_r;
                    end else begin
                        state_next = IDLE;
                    end
                end
                SHIFT: begin
                    mul_next   = {mag_r[MAG_W-4:0], 3'b000} + {mag_r[MAG_W-2:0], 1'b0};
                    state_next = ADD;
                end
                ADD: begin
                    mag_next   = mul_r + MAG_W'(dig_r);
                    count_next = count_r + CNT_ONE;
                    state_next = IDLE;
                end
                CONV: begin
                    res_next     = conv_value_s;
                    res_ovf_next = conv_ovf_s;
                    state_next   = DONE;
                end
                DONE: begin
                    value_next       = res_r;
                    overflow_next    = res_ovf_r;
                    value_valid_next = 1'b1;
                    mag_next         = '0;
                    count_next       = '0;
                    neg_next         = 1'b0;
                    state_next       = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
        busy_next = (state_next != IDLE);
    end

    // State and datapath registers; all outputs come straight from here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            mag_r         <= '0;
            mul_r         <= '0;
            dig_r         <= 4'd0;
            count_r       <= '0;
            neg_r         <= 1'b0;
            res_r         <= '0;
            res_ovf_r     <= 1'b0;
            value_r       <= '0;
            overflow_r    <= 1'b0;
            value_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_next;
            mag_r         <= mag_next;
            mul_r         <= mul_next;
            dig_r         <= dig_next;
            count_r       <= count_next;
            neg_r         <= neg_next;
            res_r         <= res_next;
            res_ovf_r     <= res_ovf_next;
            value_r       <= value_next;
            overflow_r    <= overflow_next;
            value_valid_r <= value_valid_next;
            busy_r        <= busy_next;
        end
    end

    assign busy        = busy_r;
    assign value       = value_r;
    assign value_valid = value_valid_r;
    assign overflow    = overflow_r;
    assign negative    = neg_r;
    assign digit_count = count_r;

endmodule

// File: tb/tb_bcd_entry_to_bin.sv
// Self-checking bench for bcd_entry_to_bin: directed test-plan steps then random keypad traffic vs an integer model.
module tb_bcd_entry_to_bin;

    localparam int WIDTH = 8;
    localparam int MAXD  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             digit_valid = 1'b0;
    logic [3:0]       digit = 4'd0;
    logic             sign_toggle = 1'b0;
    logic             clear = 1'b0;
    logic             commit = 1'b0;
    logic             busy;
    logic [WIDTH-1:0] value;
    logic             value_valid;
    logic             overflow;
    logic             negative;
    logic [1:0]       digit_count;

    int vectors     = 0;
    int miscompares = 0;

    // model of the entry: plain integers
    int         m_mag = 0;
    int         m_cnt = 0;
    bit         m_neg = 1'b0;
    logic [7:0] m_value = 8'h00;
    bit         m_ovf = 1'b0;

    bcd_entry_to_bin #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) dut (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
        .sign_toggle(sign_toggle), .clear(clear), .commit(commit), .busy(busy),
        .value(value), .value_valid(value_valid), .overflow(overflow),
        .negative(negative), .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input bit exp_vv);
        check({tag, "_busy"}, busy, 32'(0));
        check({tag, "_cnt"}, digit_count, m_cnt);
        check({tag, "_neg"}, negative, m_neg);
        check({tag, "_ovf"}, overflow, m_ovf);
        check({tag, "_value"}, value, m_value);
        check({tag, "_vv"}, value_valid, exp_vv);
    endtask

    task automatic press_digit(input logic [3:0] d, input bit poke);
        bit acc;
        acc = (d <= 4'd9) && (m_cnt < MAXD);
        digit_valid = 1'b1;
        digit = d;
        tick;
        digit_valid = 1'b0;
        check("dig_busy_k", busy, acc);
        if (acc) begin
            if (poke) begin
                digit_valid = 1'b1;
                digit = 4'd9;
            end
            tick;
            digit_valid = 1'b0;
            check("dig_busy_k1", busy, 32'(1));
            tick;
            m_mag = m_mag * 10 + int'(d);
            m_cnt++;
        end
        check_state("dig", 1'b0);
    endtask

    task automatic press_sign;
        sign_toggle = 1'b1;
        tick;
        sign_toggle = 1'b0;
        m_neg = !m_neg;
        check_state("sign", 1'b0);
    endtask

    task automatic press_clear;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        m_mag = 0; m_cnt = 0; m_neg = 1'b0; m_ovf = 1'b0;
        check_state("clear", 1'b0);
    endtask

    task automatic press_commit;
        int lim;
        bit ovf;
        logic [7:0] v;
        lim = m_neg ? 128 : 127;
        ovf = (m_mag > lim);
        if (ovf) begin
`ifdef SATURATE_EN
            v = m_neg ? 8'h80 : 8'h7F;
`else
            v = 8'h00;
`endif
        end else begin
            v = m_neg ? 8'(-m_mag) : 8'(m_mag);
        end
        commit = 1'b1;
        tick;
        commit = 1'b0;
        check("cm_busy_k", busy, 32'(1));
        check("cm_vv_k", value_valid, 32'(0));
        tick;
        check("cm_busy_k1", busy, 32'(1));
        check("cm_vv_k1", value_valid, 32'(0));
        tick;
        m_value = v; m_ovf = ovf; m_mag = 0; m_cnt = 0; m_neg = 1'b0;
        check_state("cm_k2", 1'b1);
        tick;
        check("cm_vv_after", value_valid, 32'(0));
    endtask

    initial begin
        int op;
        // reset state
        tick;
        tick;
        check_state("reset", 1'b0);
        rst = 1'b1;
        tick;
        check_state("post_reset", 1'b0);

        // 1,2,3 commit -> 123
        press_digit(4'd1, 1'b0);
        press_digit(4'd2, 1'b0);
        press_digit(4'd3, 1'b0);
        press_commit;
        check("tp_123", value, 32'h7B);

        // -128 in range, -129 out of range
        press_sign;
        press_digit(4'd1, 1'b0);
        press_digit(4'd2, 1'b0);
        press_digit(4'd8, 1'b0);
        press_commit;
        check("tp_m128", value, 32'h80);
        check("tp_m128_ovf", overflow, 32'(0));
        press_sign;
        press_digit(4'd1, 1'b0);
        press_digit(4'd2, 1'b0);
        press_digit(4'd9, 1'b0);
        press_commit;
        check("tp_m129_ovf", overflow, 32'(1));

        // 200 overflows; fourth digit ignored
        press_digit(4'd2, 1'b0);
        press_digit(4'd0, 1'b0);
        press_digit(4'd0, 1'b0);
        press_commit;
        check("tp_200_ovf", overflow, 32'(1));
        press_digit(4'd1, 1'b0);
        press_digit(4'd2, 1'b0);
        press_digit(4'd7, 1'b0);
        press_digit(4'd4, 1'b0);
        check("tp_cnt_full", digit_count, 32'(3));
        press_commit;
        check("tp_127", value, 32'h7F);

        // invalid digit, busy poke, clear+commit collision
        press_digit(4'hA, 1'b0);
        press_digit(4'd4, 1'b1);
        press_digit(4'd5, 1'b1);
        clear = 1'b1;
        commit = 1'b1;
        tick;
        clear = 1'b0;
        commit = 1'b0;
        m_mag = 0; m_cnt = 0; m_neg = 1'b0; m_ovf = 1'b0;
        check_state("clr_commit", 1'b0);
        tick;
        check("clr_commit_vv", value_valid, 32'(0));
        check("clr_commit_keep", value, 32'h7F);

        // clear during SHIFT aborts the digit
        press_digit(4'd6, 1'b0);
        digit_valid = 1'b1;
        digit = 4'd7;
        tick;
        digit_valid = 1'b0;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        m_mag = 0; m_cnt = 0; m_neg = 1'b0; m_ovf = 1'b0;
        check_state("clr_shift", 1'b0);

        // empty commit
        press_commit;
        check("tp_empty", value, 32'h00);

        // reset during ADD
        press_digit(4'd5, 1'b0);
        press_commit;
        digit_valid = 1'b1;
        digit = 4'd3;
        tick;
        digit_valid = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        m_mag = 0; m_cnt = 0; m_neg = 1'b0; m_ovf = 1'b0; m_value = 8'h00;
        check_state("rst_add", 1'b0);
        tick;
        rst = 1'b1;
        tick;
        check_state("rst_rel1", 1'b0);
        tick;
        check_state("rst_rel2", 1'b0);

        // random keypad traffic
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 5) begin
                press_digit(4'($urandom_range(0, 11)), ($urandom_range(0, 3) == 0));
            end else if (op == 6) begin
                press_sign;
            end else if (op <= 8) begin
                press_commit;
            end else begin
                press_clear;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
